// File: rtl/sp_port_arbiter.sv
// Two-requester arbiter for the single register-file port: IDLE -> GNT (access) -> ACK (pulse).
// Ties go to requester 1 unless SP_ARB_ROUND_ROBIN_EN is defined, which alternates on the last winner.
module sp_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = BUS_WIDTH / DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [1:0]            req_i,
    input  logic [1:0]            we_i,
    input  logic [ADDR_WIDTH-1:0] addr0_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    input  logic [BUS_WIDTH-1:0]  wdata0_i,
    input  logic [BUS_WIDTH-1:0]  wdata1_i,
    input  logic [STRB_WIDTH-1:0] strb0_i,
    input  logic [STRB_WIDTH-1:0] strb1_i,
    input  logic                  lock_i,
    input  logic [BUS_WIDTH-1:0]  mem_rdata_i,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [BUS_WIDTH-1:0]  mem_wdata_o,
    output logic [STRB_WIDTH-1:0] mem_strb_o,
    output logic [1:0]            gnt_o,
    output logic [1:0]            ack_o,
    output logic [BUS_WIDTH-1:0]  rdata_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   owner_q, owner_d;
    logic [1:0]             gnt_q, gnt_d;
    logic [1:0]             ack_q, ack_d;
    logic                   busy_q, busy_d;
    logic [BUS_WIDTH-1:0]   rdata_q, rdata_d;

    logic [1:0]             eligible;
    logic                   tie_pick;
    logic                   sel_we;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [BUS_WIDTH-1:0]   sel_wdata;
    logic [STRB_WIDTH-1:0]  sel_strb;

`ifdef SP_ARB_ROUND_ROBIN_EN
    logic                   last_q, last_d;
    assign tie_pick = ~last_q;
`else
    assign tie_pick = 1'b1;
`endif

    function automatic logic [1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    function automatic logic pick(input logic [1:0] elig, input logic tie);
        return (elig == 2'b11) ? tie : elig[1];
    endfunction

    // The lock only masks new selections; an access already owned by requester 0 runs to completion.
    assign eligible  = req_i & {1'b1, ~lock_i};

    assign sel_we    = owner_q ? we_i[1]  : we_i[0];
    assign sel_addr  = owner_q ? addr1_i  : addr0_i;
    assign sel_wdata = owner_q ? wdata1_i : wdata0_i;
    assign sel_strb  = owner_q ? strb1_i  : strb0_i;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        ack_d   = 2'b00;
        busy_d  = busy_q;
        rdata_d = rdata_q;
`ifdef SP_ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    owner_d = pick(eligible, tie_pick);
                    state_d = ST_GNT;
                    gnt_d   = onehot(owner_d);
                    busy_d  = 1'b1;
`ifdef SP_ARB_ROUND_ROBIN_EN
                    last_d  = owner_d;
`endif
                end
            end
            ST_GNT: begin
                state_d = ST_ACK;
                ack_d   = onehot(owner_q);
                if (!sel_we) begin
                    rdata_d = mem_rdata_i;
                end
            end
            ST_ACK: begin
                // The finishing owner still holds req this cycle, so only the other side is considered.
                if (eligible[~owner_q]) begin
                    owner_d = ~owner_q;
                    state_d = ST_GNT;
                    gnt_d   = onehot(~owner_q);
                    busy_d  = 1'b1;
`ifdef SP_ARB_ROUND_ROBIN_EN
                    last_d  = ~owner_q;
`endif
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = 2'b00;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            gnt_q   <= 2'b00;
            ack_q   <= 2'b00;
            busy_q  <= 1'b0;
            rdata_q <= '0;
`ifdef SP_ARB_ROUND_ROBIN_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
`ifdef SP_ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    assign mem_en_o    = (state_q == ST_GNT);
    assign mem_we_o    = mem_en_o & sel_we;
    assign mem_addr_o  = mem_en_o ? sel_addr  : '0;
    assign mem_wdata_o = mem_en_o ? sel_wdata : '0;
    assign mem_strb_o  = mem_en_o ? sel_strb  : '0;

    assign gnt_o   = gnt_q;
    assign ack_o   = ack_q;
    assign busy_o  = busy_q;
    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_sp_port_arbiter.sv
// Randomized bench for sp_port_arbiter: protocol-following requesters, a register-file stub and a
// transaction-level reference model that predicts every output each cycle.
`timescale 1ns/1ps
module tb_sp_port_arbiter;

    localparam int AW = 32;
    localparam int BW = 16;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req, we;
    logic [AW-1:0] addr0, addr1;
    logic [BW-1:0] wdata0, wdata1;
    logic [SW-1:0] strb0, strb1;
    logic          lock;
    logic [BW-1:0] mem_rdata;
    logic          mem_en_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [BW-1:0] mem_wdata_o;
    logic [SW-1:0] mem_strb_o;
    logic [1:0]    gnt_o, ack_o;
    logic [BW-1:0] rdata_o;
    logic          busy_o;

    sp_port_arbiter #(.DATA_WIDTH(8), .BUS_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .strb0_i(strb0), .strb1_i(strb1), .lock_i(lock), .mem_rdata_i(mem_rdata),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_strb_o(mem_strb_o), .gnt_o(gnt_o),
        .ack_o(ack_o), .rdata_o(rdata_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] init_val(input int i);
        return 16'(i * 4951) ^ 16'hA0A0;
    endfunction

    // Register-file stub: combinational read, byte-strobed write at the clock edge.
    logic [BW-1:0] slv_mem [16];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) slv_mem[i] <= init_val(i);
        end else if (mem_en_o && mem_we_o) begin
            if (mem_strb_o[0]) slv_mem[mem_addr_o[4:1]][7:0]  <= mem_wdata_o[7:0];
            if (mem_strb_o[1]) slv_mem[mem_addr_o[4:1]][15:8] <= mem_wdata_o[15:8];
        end
    end
    assign mem_rdata = slv_mem[mem_addr_o[4:1]];

    // Requester transactions
    logic          rq_act  [2];
    logic          rq_done [2];
    logic          rq_we   [2];
    logic [AW-1:0] rq_addr [2];
    logic [BW-1:0] rq_wdata[2];
    logic [SW-1:0] rq_strb [2];

    // Reference model: m_phase 0 = no transaction, 1 = access cycle, 2 = acknowledge cycle
    int            m_phase;
    int            m_owner;
    logic          m_last;
    logic [BW-1:0] m_rdata;
    logic [BW-1:0] m_mem [16];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        req    = {rq_act[1], rq_act[0]};
        we     = {rq_we[1], rq_we[0]};
        addr0  = rq_addr[0];  addr1  = rq_addr[1];
        wdata0 = rq_wdata[0]; wdata1 = rq_wdata[1];
        strb0  = rq_strb[0];  strb1  = rq_strb[1];
    endtask

    task automatic new_tx(input int i);
        rq_act[i]   = 1'b1;
        rq_we[i]    = 1'($urandom_range(0, 1));
        rq_addr[i]  = {27'd0, 4'($urandom_range(0, 15)), 1'b0};
        rq_wdata[i] = 16'($urandom);
        rq_strb[i]  = 2'($urandom_range(0, 3));
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_owner = 0;
        m_last  = 1'b1;
        m_rdata = '0;
        for (int i = 0; i < 16; i++) m_mem[i] = init_val(i);
    endtask

    task automatic model_step();
        logic [1:0] elig;
        int         w;
        int         idx;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_phase == 1) begin
            idx = int'(rq_addr[m_owner][4:1]);
            if (rq_we[m_owner]) begin
                if (rq_strb[m_owner][0]) m_mem[idx][7:0]  = rq_wdata[m_owner][7:0];
                if (rq_strb[m_owner][1]) m_mem[idx][15:8] = rq_wdata[m_owner][15:8];
            end else begin
                m_rdata = m_mem[idx];
            end
            m_phase = 2;
            return;
        end
        elig = req;
        if (lock) elig[0] = 1'b0;
        if (m_phase == 2) elig[m_owner] = 1'b0;
        if (elig == 2'b00) begin
            m_phase = 0;
        end else begin
            if (elig == 2'b11) begin
`ifdef SP_ARB_ROUND_ROBIN_EN
                w = m_last ? 0 : 1;
`else
                w = 1;
`endif
            end else begin
                w = elig[1] ? 1 : 0;
            end
            m_owner = w;
            m_last  = 1'(w);
            m_phase = 1;
        end
    endtask

    task automatic check_outputs();
        logic [1:0] oh;
        logic       acc;
        oh  = (m_owner == 1) ? 2'b10 : 2'b01;
        acc = (m_phase == 1);
        chk("gnt",   64'(gnt_o),   64'((m_phase != 0) ? oh : 2'b00));
        chk("ack",   64'(ack_o),   64'((m_phase == 2) ? oh : 2'b00));
        chk("busy",  64'(busy_o),  64'(m_phase != 0));
        chk("rdata", 64'(rdata_o), 64'(m_rdata));
        chk("mem_en",    64'(mem_en_o),    64'(acc));
        chk("mem_we",    64'(mem_we_o),    64'(acc ? rq_we[m_owner]    : 1'b0));
        chk("mem_addr",  64'(mem_addr_o),  64'(acc ? rq_addr[m_owner]  : 32'd0));
        chk("mem_wdata", 64'(mem_wdata_o), 64'(acc ? rq_wdata[m_owner] : 16'd0));
        chk("mem_strb",  64'(mem_strb_o),  64'(acc ? rq_strb[m_owner]  : 2'd0));
    endtask

    initial begin
        rst  = 1'b1;
        lock = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rq_act[i] = 1'b0; rq_done[i] = 1'b0; rq_we[i] = 1'b0;
            rq_addr[i] = '0; rq_wdata[i] = '0; rq_strb[i] = '0;
        end
        drive();
        model_reset();

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (rq_done[i]) begin
                    rq_act[i]  = 1'b0;
                    rq_done[i] = 1'b0;
                end else if (!rq_act[i] && $urandom_range(0, 99) < 60) begin
                    new_tx(i);
                end
            end
            if (cyc < 800)
                lock = 1'b0;
            else if (cyc < 1600) begin
                if (cyc % 12 == 0) lock = ($urandom_range(0, 2) != 0);
            end else
                lock = ($urandom_range(0, 99) < 30);
            rst = (cyc < 3) ||
                  (cyc >= 2000 && m_phase != 2 && $urandom_range(0, 19) == 0);
            drive();
            #1;
            check_outputs();
            for (int i = 0; i < 2; i++) if (ack_o[i]) rq_done[i] = 1'b1;
            model_step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
